// File: rtl/func_sched_if.sv
// Handshake bundle between the requesters, the func scheduler and the shared
// func core.
//   req_i/a_i/b_i/ack_o          : four requesters; requester k owns byte k
//   core_a_o/core_b_o/core_start_o
//   core_y_i/core_busy_i         : shared func core (y = a*b + a^3)
//   y_o/id_o/valid_o/error_o/busy_o : result and status
// The slave modport is the scheduler's view. The master modport is the
// environment's view: the requesters plus the core.
interface func_sched_if;
  logic [3:0]  req_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [3:0]  ack_o;
  logic [7:0]  core_a_o;
  logic [7:0]  core_b_o;
  logic        core_start_o;
  logic [23:0] core_y_i;
  logic        core_busy_i;
  logic [23:0] y_o;
  logic [1:0]  id_o;
  logic        valid_o;
  logic        error_o;
  logic        busy_o;

  modport slave (
    input  req_i, a_i, b_i, core_y_i, core_busy_i,
    output ack_o, core_a_o, core_b_o, core_start_o, y_o, id_o, valid_o, error_o, busy_o
  );

  modport master (
    output req_i, a_i, b_i, core_y_i, core_busy_i,
    input  ack_o, core_a_o, core_b_o, core_start_o, y_o, id_o, valid_o, error_o, busy_o
  );
endinterface

// File: rtl/func_sched.sv
// Round-robin scheduler that shares one func core between four requesters.
// Ports:
//   clk_i  - single clock, rising edge
//   rst_i  - asynchronous active-low reset
//   bus    - func_sched_if.slave (requests, operands, core handshake, results)
// Parameter TIMEOUT: WAIT_BUSY cycles allowed for core_busy_i to rise.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | no job; grant the round-robin winner and latch its operands
// ISSUE     | core_start_o for one cycle, load the timeout down-counter
// WAIT_BUSY | wait for core_busy_i; counter reaching 0 drops the job (error_o)
// WAIT_DONE | wait for core_busy_i low, capture core_y_i and the owner id
// RESULT    | valid_o for one cycle
module func_sched #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  func_sched_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESULT
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    ptr;
  logic [1:0]    own_id;
  logic [7:0]    op_a, op_b;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [23:0]   y_q;
  logic [1:0]    id_q;
  logic          grant_vld;
  logic [1:0]    grant_idx;
  logic          take, capture, err;

  // Scan offsets from 3 down to 0 so the smallest offset from ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req_i[ptr + 2'(i)]) begin
        grant_vld = 1'b1;
        grant_idx = ptr + 2'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    take      = 1'b0;
    capture   = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          take      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        tmr_nxt   = TW'(TIMEOUT);
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // TIMEOUT cycles with busy checked, then the drop cycle itself
        if (tmr == '0) begin
          err       = 1'b1;
          state_nxt = IDLE;
        end else if (bus.core_busy_i) begin
          tmr_nxt   = '0;
          state_nxt = WAIT_DONE;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.core_busy_i) begin
          capture   = 1'b1;
          state_nxt = RESULT;
        end
      end
      RESULT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      ptr    <= 2'd0;
      own_id <= 2'd0;
      op_a   <= 8'd0;
      op_b   <= 8'd0;
      tmr    <= '0;
      y_q    <= 24'd0;
      id_q   <= 2'd0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      if (take) begin
        ptr    <= grant_idx + 2'd1;
        own_id <= grant_idx;
        op_a   <= bus.a_i[{grant_idx, 3'b000} +: 8];
        op_b   <= bus.b_i[{grant_idx, 3'b000} +: 8];
      end
      if (capture) begin
        y_q  <= bus.core_y_i;
        id_q <= own_id;
      end
    end
  end

  // ack is combinational from IDLE; gating with rst_i keeps it low while
  // reset is held even if requests are already pending.
  assign bus.ack_o        = (take && rst_i) ? (4'b0001 << grant_idx) : 4'b0000;
  assign bus.core_start_o = (state == ISSUE);
  assign bus.core_a_o     = (state != IDLE) ? op_a : 8'd0;
  assign bus.core_b_o     = (state != IDLE) ? op_b : 8'd0;
  assign bus.y_o          = y_q;
  assign bus.id_o         = id_q;
  assign bus.valid_o      = (state == RESULT);
  assign bus.error_o      = err;
  assign bus.busy_o       = (state != IDLE);

endmodule

// File: tb/tb_func_sched.sv
`timescale 1ns/1ps
module tb_func_sched;
  localparam int TIMEOUT = 10;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  func_sched_if sif ();

  func_sched #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (sif)
  );

  typedef struct {
    bit         err;
    logic [1:0] id;
    logic [7:0] a;
    logic [7:0] b;
  } job_t;

  job_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          in_flight = 0;
  logic [1:0]  rr_p = 2'd0;
  logic [3:0]  last_ack = 4'd0;
  logic [23:0] last_y = 24'd0;
  logic [1:0]  last_id = 2'd0;
  int          grant_cyc = -1;
  int          start_cyc = 0;
  bit          core_hang = 0;
  int          fixed_lat = 0;
  int          drv_errs = 0;
  bit          done = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [23:0] func_ref(input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    return 24'(ia * ib + ia * ia * ia);
  endfunction

  function automatic logic [3:0] rr_pick(input logic [1:0] p, input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (int'(p) + i) % 4;
      if (r[k]) return 4'(1 << k);
    end
    return 4'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: sampled on the falling edge
  always @(negedge clk_i) begin
    logic [3:0] exp_ack;
    job_t       j;
    if (!rst_i) begin
      chk("rst_ack", sif.ack_o, 0);
      chk("rst_core_a", sif.core_a_o, 0);
      chk("rst_core_b", sif.core_b_o, 0);
      chk("rst_start", sif.core_start_o, 0);
      chk("rst_y", sif.y_o, 0);
      chk("rst_id", sif.id_o, 0);
      chk("rst_valid", sif.valid_o, 0);
      chk("rst_error", sif.error_o, 0);
      chk("rst_busy", sif.busy_o, 0);
      sb.delete();
      in_flight = 0;
      rr_p      = 2'd0;
      last_ack  = 4'd0;
      last_y    = 24'd0;
      last_id   = 2'd0;
      grant_cyc = -1;
    end else begin
      chk("exclusive", 32'($countones({|sif.ack_o, sif.valid_o, sif.error_o, sif.core_start_o}) <= 1), 1);
      chk("busy_o", sif.busy_o, in_flight);
      exp_ack = in_flight ? 4'd0 : rr_pick(rr_p, sif.req_i);
      chk("ack", sif.ack_o, exp_ack);
      last_ack = sif.ack_o;
      if (in_flight && sb.size() > 0) begin
        chk("core_a", sif.core_a_o, sb[0].a);
        chk("core_b", sif.core_b_o, sb[0].b);
      end
      if (exp_ack != 4'd0) begin
        int k;
        k = 0;
        for (int i = 0; i < 4; i++) if (exp_ack[i]) k = i;
        j.err = core_hang;
        j.id  = 2'(k);
        j.a   = sif.a_i[8*k +: 8];
        j.b   = sif.b_i[8*k +: 8];
        sb.push_back(j);
        if (grant_cyc >= 0) chk("grant_spacing", 32'(cyc - grant_cyc >= 5), 1);
        grant_cyc = cyc;
        in_flight = 1;
        rr_p      = 2'(k + 1);
      end
      if (sif.core_start_o) begin
        chk("start_latency", cyc, grant_cyc + 1);
        start_cyc = cyc;
      end
      if (sif.valid_o) begin
        if (sb.size() == 0) begin
          chk("valid_unexpected", 1, 0);
        end else begin
          j = sb.pop_front();
          chk("valid_kind", j.err, 0);
          chk("y", sif.y_o, func_ref(j.a, j.b));
          chk("id", sif.id_o, j.id);
          last_y  = func_ref(j.a, j.b);
          last_id = j.id;
        end
        in_flight = 0;
      end else begin
        chk("y_hold", sif.y_o, last_y);
        chk("id_hold", sif.id_o, last_id);
      end
      if (sif.error_o) begin
        if (sb.size() == 0) begin
          chk("error_unexpected", 1, 0);
        end else begin
          j = sb.pop_front();
          chk("error_kind", j.err, 1);
          chk("error_time", cyc, start_cyc + 1 + TIMEOUT);
        end
        in_flight = 0;
      end
    end
    if (done) begin
      chk("sb_empty", sb.size(), 0);
      chk("driver_waits", drv_errs, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // Core model: busy for a random number of cycles, garbage on y while busy
  initial begin
    logic [7:0] ca, cb;
    int lat;
    sif.core_busy_i = 1'b0;
    sif.core_y_i    = 24'd0;
    forever begin
      @(negedge clk_i);
      if (rst_i && sif.core_start_o && !core_hang) begin
        ca  = sif.core_a_o;
        cb  = sif.core_b_o;
        lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
        @(posedge clk_i);
        #1;
        sif.core_busy_i = 1'b1;
        sif.core_y_i    = 24'($urandom);
        repeat (lat) @(posedge clk_i);
        #1;
        sif.core_y_i    = 24'(int'(ca) * int'(cb) + int'(ca) * int'(ca) * int'(ca));
        sif.core_busy_i = 1'b0;
      end
    end
  end

  // Every driver step goes through tick so a granted request always drops
  task automatic tick();
    @(posedge clk_i);
    #1;
    sif.req_i = sif.req_i & ~last_ack;
  endtask

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b);
    sif.a_i[8*k +: 8] = a;
    sif.b_i[8*k +: 8] = b;
    sif.req_i[k]      = 1'b1;
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    tick();
    while ((in_flight || sif.req_i != 4'd0 || sif.core_busy_i) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      drv_errs++;
      $display("FAIL wait_quiet: still busy after %0d cycles", budget);
    end
  endtask

  initial begin
    sif.req_i = 4'd0;
    sif.a_i   = 32'd0;
    sif.b_i   = 32'd0;
    // 2*2 + 2^3 = 12, request pending through reset
    fixed_lat = 3;
    set_req(0, 8'd2, 8'd2);
    repeat (4) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    wait_quiet(50);
    fixed_lat = 0;

    // corner operands; requester 3 leaves the pointer at 0
    set_req(3, 8'd255, 8'd255);
    wait_quiet(50);
    set_req(3, 8'd0, 8'd0);
    wait_quiet(50);
    set_req(3, 8'd1, 8'd0);
    wait_quiet(50);

    // all four held, twice
    repeat (2) begin
      for (int k = 0; k < 4; k++) set_req(k, 8'($urandom), 8'($urandom));
      wait_quiet(100);
    end

    // after a grant to 1, 3 must win over 1
    set_req(1, 8'd7, 8'd9);
    tick();
    tick();
    set_req(1, 8'd11, 8'd13);
    set_req(3, 8'd17, 8'd19);
    wait_quiet(60);

    // core never answers, then a normal job
    core_hang = 1;
    set_req(2, 8'd5, 8'd6);
    wait_quiet(60);
    core_hang = 0;
    set_req(2, 8'd8, 8'd3);
    wait_quiet(60);

    // random traffic with occasional withdrawals
    repeat (400) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        if (!sif.req_i[k] && ($urandom % 4) == 0)
          set_req(k, 8'($urandom), 8'($urandom));
        else if (sif.req_i[k] && ($urandom % 32) == 0)
          sif.req_i[k] = 1'b0;
      end
    end
    wait_quiet(300);

    // reset in WAIT_DONE, then the requester asks again
    fixed_lat = 6;
    set_req(1, 8'd200, 8'd77);
    begin
      int n;
      n = 0;
      while (!sif.core_busy_i && n < 20) begin
        tick();
        n++;
      end
      if (n >= 20) begin
        drv_errs++;
        $display("FAIL wait_core_busy: no busy after 20 cycles");
      end
    end
    tick();
    rst_i = 1'b0;
    repeat (10) tick();
    rst_i = 1'b1;
    fixed_lat = 2;
    set_req(1, 8'd200, 8'd77);
    wait_quiet(60);

    done = 1;
    repeat (5) @(posedge clk_i);
    $display("FAIL tb_end: monitor did not finish");
    $fatal(1);
  end
endmodule
